// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency word reads and
// buffers returned instructions in a small FIFO feeding decode over valid/ready.
module instruction_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_infl;
    logic [31:0]       r_instr [DEPTH];
    logic [ADDR_W-1:0] r_ipc   [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [CNT_W:0]    w_pending;

    // Occupancy the FIFO will reach counting the response already in flight;
    // issuing only while it is below DEPTH makes overflow impossible.
    assign w_pending = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_infl) - (CNT_W+1)'(w_pop);
    assign w_issue   = !rst && !halt && !redirect_valid && (w_pending < (CNT_W+1)'(DEPTH));
    assign w_push    = r_infl && !redirect_valid;

    assign out_valid = (r_count != '0) && !redirect_valid;
    assign w_pop     = out_valid && out_ready;
    assign imem_req  = w_issue;
    assign imem_addr = r_pc;
    assign out_instr = r_instr[r_rd_ptr];
    assign out_pc    = r_ipc[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_infl   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_ipc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            // Squash everything younger than the redirect, including this cycle's response.
            r_pc     <= redirect_pc;
            r_infl   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_infl <= w_issue;
            if (w_issue) begin
                r_pc     <= r_pc + ADDR_W'(1);
                r_req_pc <= r_pc;
            end
            if (w_push) begin
                r_instr[r_wr_ptr] <= imem_rdata;
                r_ipc[r_wr_ptr]   <= r_req_pc;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: an in-order scoreboard of expected PCs
// checks every accepted instruction, plus cycle-exact latency/redirect/halt checks.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    logic        u4_req;
    logic [3:0]  u4_addr;
    logic [31:0] u4_rdata;
    logic        u4_valid;
    logic [31:0] u4_instr;
    logic [3:0]  u4_pc;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    instruction_fetch #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    instruction_fetch #(.ADDR_W(4), .RESET_PC(4'hE), .DEPTH(2)) dut4 (
        .clk(clk), .rst(rst),
        .imem_req(u4_req), .imem_addr(u4_addr), .imem_rdata(u4_rdata),
        .redirect_valid(1'b0), .redirect_pc(4'h0), .halt(1'b0),
        .out_valid(u4_valid), .out_ready(1'b1),
        .out_instr(u4_instr), .out_pc(u4_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Synchronous instruction memories with 1-cycle latency
    always @(posedge clk) begin
        imem_rdata <= instr_of(imem_addr);
        u4_rdata   <= {28'h0, u4_addr} + 32'h100;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_reset(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every accepted instruction must be the next expected PC, in order
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [31:0] e;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            chk("sb_pc", out_pc, e);
            chk("sb_instr", out_instr, instr_of(e));
        end
    end

    initial begin
        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        step(); step();
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_u4_valid", 32'(u4_valid), 32'd0);

        // Reset release: cycle 0 begins
        rst = 1'b0;
        sb_reset(32'h0);
        #1;
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, 32'd0);
        step();
        chk("c1_valid", 32'(out_valid), 32'd0);
        chk("c1_u4_valid", 32'(u4_valid), 32'd0);
        step();
        chk("c2_valid", 32'(out_valid), 32'd1);
        chk("c2_pc", out_pc, 32'd0);
        chk("c2_u4_valid", 32'(u4_valid), 32'd1);
        chk("c2_u4_pc", 32'(u4_pc), 32'hE);
        chk("c2_u4_instr", u4_instr, 32'h10E);
        step();
        chk("c3_u4_pc", 32'(u4_pc), 32'hF);
        step();
        chk("c4_u4_pc_wrap", 32'(u4_pc), 32'h0);
        chk("c4_u4_instr_wrap", u4_instr, 32'h100);
        step(); step();

        // Backpressure at out_pc=4 for 5 cycles
        chk("bp_start_pc", out_pc, 32'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_pc", out_pc, 32'd4);
            chk("bp_hold_instr", out_instr, instr_of(32'd4));
            if (i < 4) step();
        end
        chk("bp_req_low", 32'(imem_req), 32'd0);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("bp_nogap_valid", 32'(out_valid), 32'd1);
            step();
        end

        // Redirect with fetches in flight
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        sb_reset(32'h40);
        #1;
        chk("rd_r_valid", 32'(out_valid), 32'd0);
        chk("rd_r_req", 32'(imem_req), 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("rd_r1_req", 32'(imem_req), 32'd1);
        chk("rd_r1_addr", imem_addr, 32'h40);
        chk("rd_r1_valid", 32'(out_valid), 32'd0);
        step();
        chk("rd_r2_valid", 32'(out_valid), 32'd0);
        step();
        chk("rd_r3_valid", 32'(out_valid), 32'd1);
        chk("rd_r3_pc", out_pc, 32'h40);
        step();
        chk("rd_r4_pc", out_pc, 32'h41);

        // Redirect while FIFO is full and decode is ready
        out_ready = 1'b0;
        step(); step(); step();
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_req", 32'(imem_req), 32'd0);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        sb_reset(32'h80);
        #1;
        chk("full_rd_valid", 32'(out_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        step(); step();
        chk("full_rd_r3_pc", out_pc, 32'h80);
        step(); step();

        // Back-to-back redirects: the second one wins
        redirect_valid = 1'b1; redirect_pc = 32'h90;
        sb_reset(32'h90);
        step();
        redirect_pc = 32'hA0;
        sb_reset(32'hA0);
        #1;
        chk("b2b_req", 32'(imem_req), 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("b2b_addr", imem_addr, 32'hA0);
        chk("b2b_req1", 32'(imem_req), 32'd1);
        step(); step();
        chk("b2b_pc", out_pc, 32'hA0);
        chk("b2b_valid", 32'(out_valid), 32'd1);
        step(); step();

        // Halt for 4 cycles mid-stream
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("halt_req", 32'(imem_req), 32'd0);
            step();
        end
        halt = 1'b0;
        #1;
        chk("halt_resume_req", 32'(imem_req), 32'd1);
        step(); step(); step(); step(); step();

        // Asynchronous reset pulse between clock edges
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        #1;
        rst = 1'b0;
        sb_reset(32'h0);
        #1;
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_req1", 32'(imem_req), 32'd1);
        step();
        chk("arst_c1_valid", 32'(out_valid), 32'd0);
        step();
        chk("arst_c2_valid", 32'(out_valid), 32'd1);
        chk("arst_c2_pc", out_pc, 32'd0);
        step(); step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
